// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan decoder: the segment code table,
// the blank pattern and the capture FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segments {g,f,e,d,c,b,a}; entry i is the pattern for hex digit i.
    localparam logic [6:0] SEG_CODE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        WAIT_SEL = 2'd0,
        SETTLING = 2'd1,
        CAPTURE  = 2'd2,
        HOLD     = 2'd3
    } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational reverse lookup of an active-low segment pattern into a hex nibble.
// Patterns outside the 16-entry code table report hit=0.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        hit    = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == SEG_CODE[i]) begin
                hit    = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Loopback monitor for a multiplexed active-low 7-segment bus: recovers the hex digit
// shown at each position and publishes it once AGREE consecutive windows agree.
//
// state    | meaning
// WAIT_SEL | no legal digit select on the bus
// SETTLING | one digit selected, counting stable cycles before sampling seg
// CAPTURE  | decode the sampled pattern and update that digit's history
// HOLD     | digit already captured this window, waiting for the select to change
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int SETTLE = 4,
    parameter int AGREE  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            seg,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  pattern_err,
    output logic                  frame_done
);

    localparam int CW = $clog2(SETTLE + 1);
    localparam int AW = $clog2(AGREE + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIGITS-1:0] an_m, an_s;
    logic [6:0]        seg_m, seg_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_m  <= '1;
            an_s  <= '1;
            seg_m <= SEG_BLANK;
            seg_s <= SEG_BLANK;
        end else begin
            an_m  <= an;
            an_s  <= an_m;
            seg_m <= seg;
            seg_s <= seg_m;
        end
    end

    logic          legal;
    logic [IW-1:0] sel_idx;

    always_comb begin
        legal   = $onehot(~an_s);
        sel_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_s[i]) sel_idx = IW'(i);
        end
    end

    state_t            state, state_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [6:0]        smp_seg, smp_seg_d;
    logic [IW-1:0]     smp_idx, smp_idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= WAIT_SEL;
            sel_q   <= '1;
            cnt     <= '0;
            smp_seg <= SEG_BLANK;
            smp_idx <= '0;
        end else begin
            state   <= state_d;
            sel_q   <= sel_d;
            cnt     <= cnt_d;
            smp_seg <= smp_seg_d;
            smp_idx <= smp_idx_d;
        end
    end

    // The select is compared against the one latched at window start, so a change
    // landing during CAPTURE is still seen from HOLD.
    always_comb begin
        state_d   = state;
        sel_d     = sel_q;
        cnt_d     = cnt;
        smp_seg_d = smp_seg;
        smp_idx_d = smp_idx;
        case (state)
            WAIT_SEL: begin
                if (legal) begin
                    state_d = SETTLING;
                    sel_d   = an_s;
                    cnt_d   = CW'(1);
                end
            end
            SETTLING: begin
                if (an_s != sel_q) begin
                    if (legal) begin
                        sel_d = an_s;
                        cnt_d = CW'(1);
                    end else begin
                        state_d = WAIT_SEL;
                    end
                end else if (cnt == CW'(SETTLE)) begin
                    smp_seg_d = seg_s;
                    smp_idx_d = sel_idx;
                    state_d   = CAPTURE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            CAPTURE: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (an_s != sel_q) begin
                    if (legal) begin
                        state_d = SETTLING;
                        sel_d   = an_s;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = WAIT_SEL;
                    end
                end
            end
            default: state_d = WAIT_SEL;
        endcase
    end

    logic          hit;
    logic [3:0]    nib;

    seg7_to_hex u_seg7_to_hex (
        .seg    (smp_seg),
        .hit    (hit),
        .nibble (nib)
    );

    logic [3:0]        cand  [DIGITS];
    logic [AW-1:0]     agree [DIGITS];
    logic [DIGITS-1:0] seen;
    logic [AW-1:0]     agree_nx;
    logic              accept;
    logic [DIGITS-1:0] seen_nx;

    always_comb begin
        if (nib == cand[smp_idx]) begin
            agree_nx = (agree[smp_idx] == AW'(AGREE)) ? agree[smp_idx] : agree[smp_idx] + 1'b1;
        end else begin
            agree_nx = AW'(1);
        end
        accept  = (state == CAPTURE) && hit && (agree_nx == AW'(AGREE));
        seen_nx = accept ? (seen | (DIGITS'(1) << smp_idx)) : seen;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DIGITS; i++) begin
                cand[i]  <= '0;
                agree[i] <= '0;
            end
            seen        <= '0;
            value       <= '0;
            digit_valid <= '0;
            pattern_err <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            pattern_err <= (state == CAPTURE) && !hit;
            if (state == CAPTURE) begin
                if (hit) begin
                    cand[smp_idx]  <= nib;
                    agree[smp_idx] <= agree_nx;
                end else begin
                    agree[smp_idx] <= '0;
                end
            end
            if (accept) begin
                value[4*int'(smp_idx) +: 4] <= nib;
                digit_valid[smp_idx]        <= 1'b1;
            end
            if (&seen_nx) begin
                frame_done <= 1'b1;
                seen       <= '0;
            end else begin
                frame_done <= 1'b0;
                seen       <= seen_nx;
            end
        end
    end

endmodule
